// File: rtl/frame_update_scheduler_if.sv
// Start/done handshake bundle between the frame scheduler and the four update units.
interface frame_update_scheduler_if;
  logic bird_start;
  logic pipe_start;
  logic coll_start;
  logic score_start;
  logic bird_done;
  logic pipe_done;
  logic coll_done;
  logic coll_hit;
  logic score_done;

  modport master (
    output bird_start, pipe_start, coll_start, score_start,
    input  bird_done, pipe_done, coll_done, coll_hit, score_done
  );

  modport slave (
    input  bird_start, pipe_start, coll_start, score_start,
    output bird_done, pipe_done, coll_done, coll_hit, score_done
  );
endinterface

// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: bird -> pipe -> collision -> score, each step gated on the previous done.
// Optional per-step watchdog is compiled in when FUS_TIMEOUT_EN is defined.
module frame_update_scheduler #(
  parameter int unsigned FRAME_CNT_W    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 game_state,
  input  logic                       frame_tick,
  frame_update_scheduler_if.master   units,
  output logic                       busy,
  output logic                       update_done,
  output logic                       collision,
  output logic                       overrun,
  output logic                       timeout_err,
  output logic [FRAME_CNT_W-1:0]     frame_count
);

  localparam logic [3:0] GS_START_SCREEN = 4'b0001;
  localparam logic [3:0] GS_IN_GAME      = 4'b0010;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("frame_update_scheduler: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIRD  = 3'd1,
    S_PIPE  = 3'd2,
    S_COLL  = 3'd3,
    S_SCORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   entry_q;
  logic   in_game_c, start_screen_c, step_done_c, timed_out_c;

  logic                   bird_start_d, pipe_start_d, coll_start_d, score_start_d;
  logic                   busy_d, update_done_d, collision_d, overrun_d, timeout_err_d;
  logic [FRAME_CNT_W-1:0] frame_count_d;

  // Non-one-hot encodings compare unequal, so they count as not in game.
  assign in_game_c      = (game_state == GS_IN_GAME);
  assign start_screen_c = (game_state == GS_START_SCREEN);

  // A done coincident with its own start strobe (entry cycle) is ignored.
  always_comb begin
    step_done_c = 1'b0;
    if (!entry_q) begin
      case (state_q)
        S_BIRD:  step_done_c = units.bird_done;
        S_PIPE:  step_done_c = units.pipe_done;
        S_COLL:  step_done_c = units.coll_done;
        S_SCORE: step_done_c = units.score_done;
        default: step_done_c = 1'b0;
      endcase
    end
  end

`ifdef FUS_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            in_step_c;

  assign in_step_c = (state_q == S_BIRD) || (state_q == S_PIPE) ||
                     (state_q == S_COLL) || (state_q == S_SCORE);

  // Counts cycles since the current step's strobe; zero in the entry cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt_q <= '0;
    else if (state_d != state_q) to_cnt_q <= '0;
    else if (in_step_c)          to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign timed_out_c = in_step_c && !step_done_c &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
    end
  end

  // Leaving IN_GAME lets the current step finish but starts nothing further.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (frame_tick && in_game_c) state_d = S_BIRD;
      S_BIRD: begin
        if (step_done_c)      state_d = in_game_c ? S_PIPE : S_IDLE;
        else if (timed_out_c) state_d = S_IDLE;
      end
      S_PIPE: begin
        if (step_done_c)      state_d = in_game_c ? S_COLL : S_IDLE;
        else if (timed_out_c) state_d = S_IDLE;
      end
      S_COLL: begin
        if (step_done_c) begin
          if (!in_game_c)         state_d = S_IDLE;
          else if (units.coll_hit) state_d = S_DONE;
          else                    state_d = S_SCORE;
        end else if (timed_out_c) begin
          state_d = S_IDLE;
        end
      end
      S_SCORE: begin
        if (step_done_c)      state_d = in_game_c ? S_DONE : S_IDLE;
        else if (timed_out_c) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs, derived from the upcoming transition.
  always_comb begin
    bird_start_d  = (state_d == S_BIRD)  && (state_q != S_BIRD);
    pipe_start_d  = (state_d == S_PIPE)  && (state_q != S_PIPE);
    coll_start_d  = (state_d == S_COLL)  && (state_q != S_COLL);
    score_start_d = (state_d == S_SCORE) && (state_q != S_SCORE);
    busy_d        = (state_d != S_IDLE);
    update_done_d = (state_d == S_DONE);
    collision_d   = (state_q == S_COLL) && step_done_c && units.coll_hit;
    overrun_d     = overrun | (frame_tick && (state_q != S_IDLE));
    timeout_err_d = timeout_err | timed_out_c;
    frame_count_d = frame_count;
    if (state_d == S_DONE) frame_count_d = frame_count + FRAME_CNT_W'(1);
    if (start_screen_c) begin
      overrun_d     = 1'b0;
      timeout_err_d = 1'b0;
      frame_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units.bird_start  <= 1'b0;
      units.pipe_start  <= 1'b0;
      units.coll_start  <= 1'b0;
      units.score_start <= 1'b0;
      busy              <= 1'b0;
      update_done       <= 1'b0;
      collision         <= 1'b0;
      overrun           <= 1'b0;
      timeout_err       <= 1'b0;
      frame_count       <= '0;
    end else begin
      units.bird_start  <= bird_start_d;
      units.pipe_start  <= pipe_start_d;
      units.coll_start  <= coll_start_d;
      units.score_start <= score_start_d;
      busy              <= busy_d;
      update_done       <= update_done_d;
      collision         <= collision_d;
      overrun           <= overrun_d;
      timeout_err       <= timeout_err_d;
      frame_count       <= frame_count_d;
    end
  end

endmodule
